axis_pattern_gen: RTL and testbench

- Single-clock AXI-stream traffic source that drives packetised test patterns into a stream slave, typically the write side of the fifo.
- Runs a programmed burst of packets with an optional inter-packet gap.
- A throttle input, normally tied to the fifo's prog_full, stops new beats from being offered.
- Serves as the producer-end counterpart for bring-up and throughput testing of the streaming path.

---
 rtl/axis_pattern_gen_if.sv | 12 +
 rtl/axis_pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pattern_gen_if.sv
// AXI-stream style handshake bundle used by the pattern generator.
// The master drives data/valid and samples ready; a beat transfers when valid & ready.
interface Axis #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport Master (output data, output valid, input ready);
    modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/axis_pattern_gen.sv
// Packetised AXI-stream traffic source: bursts of incrementing or LFSR data
// with optional inter-packet gaps, a throttle input and early abort.
module axis_pattern_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 16,
    parameter int GAP_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    Axis.Master              m_stream,
    output logic             last,
    input  logic             start,
    input  logic             abort,
    input  logic             throttle,
    input  logic             mode,
    input  logic [31:0]      seed,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [LEN_W-1:0] num_pkts,
    input  logic [GAP_W-1:0] gap_cycles,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [31:0]      beat_total
);

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    state_t           r_state;
    logic             r_valid;
    logic             r_last;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic             r_abort_pend;
    logic [31:0]      r_beat_total;
    logic [31:0]      r_pat;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [LEN_W-1:0] r_pkt_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_mode;
    logic [LEN_W-1:0] r_pkt_len;
    logic [LEN_W-1:0] r_num_pkts;
    logic [GAP_W-1:0] r_gap;

    logic                  w_ok;
    logic                  w_abort;
    logic                  w_final_pkt;
    logic                  w_cur_last;
    logic                  w_next_last;
    logic [LEN_W-1:0]      w_next_beat;
    logic [31:0]           w_pat_next;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_ok        = r_valid & m_stream.ready;
    // An abort seen while a beat is stalled is remembered until that beat drains.
    assign w_abort     = abort | r_abort_pend;
    assign w_final_pkt = (r_pkt_cnt == r_num_pkts - LEN_W'(1));
    assign w_cur_last  = (r_beat_cnt == r_pkt_len - LEN_W'(1));
    assign w_next_beat = r_last ? '0 : r_beat_cnt + LEN_W'(1);
    assign w_next_last = (w_next_beat == r_pkt_len - LEN_W'(1));
    assign w_pat_next  = r_mode ? lfsr_next(r_pat) : r_pat + 32'd1;

    generate
        if (DATA_WIDTH <= 32) begin : g_trunc
            assign w_data = r_pat[DATA_WIDTH-1:0];
        end else begin : g_zext
            assign w_data = {{(DATA_WIDTH-32){1'b0}}, r_pat};
        end
    endgenerate

    assign m_stream.data  = w_data;
    assign m_stream.valid = r_valid;
    assign last           = r_last;
    assign busy           = r_busy;
    assign done           = r_done;
    assign aborted        = r_aborted;
    assign beat_total     = r_beat_total;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_beat_total <= '0;
            r_pat        <= '0;
            r_beat_cnt   <= '0;
            r_pkt_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_mode       <= 1'b0;
            r_pkt_len    <= '0;
            r_num_pkts   <= '0;
            r_gap        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode       <= mode;
                        r_pkt_len    <= pkt_len;
                        r_num_pkts   <= num_pkts;
                        r_gap        <= gap_cycles;
                        r_pat        <= (mode && seed == 32'd0) ? 32'd1 : seed;
                        r_beat_total <= '0;
                        r_aborted    <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_beat_cnt   <= '0;
                        r_pkt_cnt    <= '0;
                        if (pkt_len == '0 || num_pkts == '0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SEND;
                            r_busy  <= 1'b1;
                            // First beat goes out the cycle after start unless throttled.
                            if (!throttle) begin
                                r_valid <= 1'b1;
                                r_last  <= (pkt_len == LEN_W'(1));
                            end
                        end
                    end
                end

                SEND: begin
                    if (r_valid) begin
                        if (w_ok) begin
                            r_beat_total <= r_beat_total + 32'd1;
                            r_pat        <= w_pat_next;
                            r_beat_cnt   <= w_next_beat;
                            if (r_last) begin
                                r_pkt_cnt <= r_pkt_cnt + LEN_W'(1);
                            end
                            if ((r_last && w_final_pkt) || w_abort) begin
                                r_valid   <= 1'b0;
                                r_last    <= 1'b0;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                                r_state   <= FIN;
                                r_aborted <= !(r_last && w_final_pkt);
                            end else if (r_last && r_gap != '0) begin
                                r_valid   <= 1'b0;
                                r_last    <= 1'b0;
                                r_gap_cnt <= r_gap;
                                r_state   <= GAP;
                            end else begin
                                r_valid <= !throttle;
                                r_last  <= !throttle && w_next_last;
                            end
                        end else if (abort) begin
                            r_abort_pend <= 1'b1;
                        end
                    end else if (w_abort) begin
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                        r_state   <= FIN;
                    end else if (!throttle) begin
                        r_valid <= 1'b1;
                        r_last  <= w_cur_last;
                    end
                end

                GAP: begin
                    if (w_abort) begin
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                        r_state   <= FIN;
                    end else if (r_gap_cnt == GAP_W'(1)) begin
                        // Offer on the exit edge so valid is low for exactly the gap length.
                        r_state <= SEND;
                        if (!throttle) begin
                            r_valid <= 1'b1;
                            r_last  <= w_cur_last;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                FIN: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Scoreboard bench for axis_pattern_gen: directed runs push expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_axis_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        throttle;
    logic        mode;
    logic [31:0] seed;
    logic [15:0] pkt_len;
    logic [15:0] num_pkts;
    logic [7:0]  gap_cycles;
    logic        ready;
    logic        last;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] beat_total;

    always #5 clk = ~clk;

    Axis #(.DATA_WIDTH(32)) axs ();
    assign axs.ready = ready;

    axis_pattern_gen #(.DATA_WIDTH(32), .LEN_W(16), .GAP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_stream   (axs),
        .last       (last),
        .start      (start),
        .abort      (abort),
        .throttle   (throttle),
        .mode       (mode),
        .seed       (seed),
        .pkt_len    (pkt_len),
        .num_pkts   (num_pkts),
        .gap_cycles (gap_cycles),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .beat_total (beat_total)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] exp_q[$];
    logic [32:0] e;
    int          low_runs[$];
    int          low_run = 0;
    int          ok_count = 0;
    int          first_ok = -1;
    int          last_ok = -1;
    logic        p_rst = 1'b0;
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic        p_throttle = 1'b0;
    logic        p_last = 1'b0;
    logic [31:0] p_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Monitor: handshake rules plus scoreboard pop on every accepted beat.
    always @(negedge clk) begin
        if (rst && p_rst) begin
            if (p_valid && !p_ready) begin
                chk("hold_valid", axs.valid, 1);
                chk("hold_data", axs.data, p_data);
                chk("hold_last", last, p_last);
            end
            if (p_throttle && (!p_valid || p_ready))
                chk("throttle_no_offer", axs.valid, 0);
        end
        if (rst && axs.valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data 0x%0h, required no beat", axs.data);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", axs.data, e[31:0]);
                chk("beat_last", last, e[32]);
            end
            ok_count++;
            if (first_ok < 0) first_ok = cyc;
            last_ok = cyc;
        end
        if (!rst || !busy) begin
            low_run = 0;
        end else if (!axs.valid) begin
            low_run++;
        end else begin
            if (low_run > 0) low_runs.push_back(low_run);
            low_run = 0;
        end
        p_rst      = rst;
        p_valid    = axs.valid;
        p_ready    = ready;
        p_throttle = throttle;
        p_data     = axs.data;
        p_last     = last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic reset_mon();
        first_ok = -1;
        last_ok  = -1;
        ok_count = 0;
        low_runs.delete();
    endtask

    task automatic start_run(input logic m, input logic [31:0] s, input logic [15:0] len,
                             input logic [15:0] num, input logic [7:0] gap, output int scyc);
        mode       = m;
        seed       = s;
        pkt_len    = len;
        num_pkts   = num;
        gap_cycles = gap;
        start      = 1'b1;
        scyc       = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
        tick();
        if (dcyc >= 0) chk({name, "_done_width"}, done, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int s, d;
        logic [31:0] lf;
        logic got;
        rst = 1'b0; start = 1'b0; abort = 1'b0; throttle = 1'b0; mode = 1'b0;
        seed = '0; pkt_len = '0; num_pkts = '0; gap_cycles = '0; ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", axs.valid, 0);
        chk("rst_last", last, 0);
        chk("rst_data", axs.data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_beat_total", beat_total, 0);
        rst = 1'b1;
        tick();

        // Test 1: incrementing, two packets of four, no gap.
        ready = 1'b1;
        reset_mon();
        for (int i = 0; i < 8; i++) push(32'h10 + i, (i % 4) == 3);
        start_run(1'b0, 32'h10, 16'd4, 16'd2, 8'd0, s);
        chk("t1_busy_run", busy, 1);
        wait_done("t1", 50, d);
        chk("t1_latency", first_ok - s, 1);
        chk("t1_span", last_ok - first_ok, 7);
        chk("t1_done_lat", d - last_ok, 1);
        chk("t1_beats", ok_count, 8);
        chk("t1_beat_total", beat_total, 8);
        chk("t1_busy_end", busy, 0);
        chk("t1_aborted", aborted, 0);
        chk("t1_q_empty", exp_q.size(), 0);

        // Test 2: three packets of three with a five-cycle gap.
        reset_mon();
        for (int i = 0; i < 9; i++) push(32'h40 + i, (i % 3) == 2);
        start_run(1'b0, 32'h40, 16'd3, 16'd3, 8'd5, s);
        wait_done("t2", 100, d);
        chk("t2_gap_count", low_runs.size(), 2);
        for (int i = 0; i < low_runs.size(); i++) chk("t2_gap_len", low_runs[i], 5);
        chk("t2_beat_total", beat_total, 9);
        chk("t2_q_empty", exp_q.size(), 0);

        // Test 3: LFSR with seed 0, random ready and throttle, 100 beats.
        reset_mon();
        push(32'h0000_0001, 1'b0);
        push(32'h8020_0003, 1'b0);
        push(32'hC030_0002, 1'b0);
        lf = 32'hC030_0002;
        for (int i = 3; i < 100; i++) begin
            lf = ref_lfsr(lf);
            push(lf, (i % 10) == 9);
        end
        start_run(1'b1, 32'h0, 16'd10, 16'd10, 8'd0, s);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            ready    = 1'($urandom_range(0, 1));
            throttle = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (done) got = 1'b1;
            tick();
        end
        ready = 1'b1;
        throttle = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL t3_done: done not seen within 3000 cycles");
        end
        chk("t3_beats", ok_count, 100);
        chk("t3_beat_total", beat_total, 100);
        chk("t3_q_empty", exp_q.size(), 0);

        // Test 4: abort while a beat is stalled.
        ready = 1'b0;
        reset_mon();
        push(32'h100, 1'b0);
        start_run(1'b0, 32'h100, 16'd4, 16'd2, 8'd0, s);
        abort = 1'b1;
        repeat (3) tick();
        abort = 1'b0;
        ready = 1'b1;
        wait_done("t4", 20, d);
        chk("t4_done_lat", d - last_ok, 1);
        chk("t4_beats", ok_count, 1);
        chk("t4_aborted", aborted, 1);
        chk("t4_beat_total", beat_total, 1);
        chk("t4_busy", busy, 0);
        repeat (3) tick();
        chk("t4_no_valid", axs.valid, 0);
        chk("t4_q_empty", exp_q.size(), 0);

        // Test 5: zero-length packet run; also clears aborted.
        reset_mon();
        start_run(1'b0, 32'h5, 16'd0, 16'd3, 8'd0, s);
        chk("t5_done", done, 1);
        chk("t5_aborted_clr", aborted, 0);
        chk("t5_valid", axs.valid, 0);
        chk("t5_beat_total", beat_total, 0);
        tick();
        chk("t5_done_width", done, 0);
        chk("t5_beats", ok_count, 0);

        // Test 6: reset mid-packet with a stalled beat, then a clean rerun.
        reset_mon();
        ready = 1'b1;
        push(32'h20, 1'b0); push(32'h21, 1'b0); push(32'h22, 1'b0);
        start_run(1'b0, 32'h20, 16'd8, 16'd2, 8'd0, s);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (ok_count >= 3) break;
        end
        @(posedge clk);
        #1;
        ready = 1'b0;
        tick();
        chk("t6_stuck_valid", axs.valid, 1);
        chk("t6_pre_total", beat_total, 3);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b0;
        tick();
        chk("t6_rst_valid", axs.valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_total", beat_total, 0);
        rst = 1'b1;
        tick();
        ready = 1'b1;
        reset_mon();
        push(32'hAB, 1'b0);
        push(32'hAC, 1'b1);
        start_run(1'b0, 32'hAB, 16'd2, 16'd1, 8'd0, s);
        wait_done("t6", 30, d);
        chk("t6_beats", ok_count, 2);
        chk("t6_beat_total", beat_total, 2);
        chk("t6_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
